// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment display driver.
// Holds the digit count, the conversion FSM state type, the active-low
// segment encodings, and the double-dabble nibble correction helper.
// Segment vectors are ordered {g,f,e,d,c,b,a}; a 0 lights a segment.
package ssd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  // Active-low segment pattern for one decimal digit; anything above 9 is blanked.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 so the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] scratch);
    logic [15:0] adj;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
      else
        adj[i*4 +: 4] = scratch[i*4 +: 4];
    end
    return adj;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous, active-low reset
//   value     - unsigned binary input, WIDTH bits
//   bcd       - last completed result {thousands,hundreds,tens,units}
//   bcd_valid - set once the first conversion has finished
//   busy      - high while a conversion is in flight
// A new conversion starts whenever the input differs from the last value
// converted, or when no result exists yet. Input changes while busy are
// ignored. The IDLE state compares the input again after DONE, so the
// result converges on the latest input. bcd only changes in DONE, which
// means a partially shifted result is never visible at the output.
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  output logic [15:0]      bcd,
  output logic             bcd_valid,
  output logic             busy
);

  conv_state_t      state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] captured;
  logic [WIDTH-1:0] last_value;
  logic [15:0]      scratch;
  logic [3:0]       shift_cnt;
  logic [15:0]      scratch_adj;

  assign scratch_adj = dabble_adjust(scratch);

  // Conversion FSM: capture, WIDTH shift steps, then publish the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      captured   <= '0;
      last_value <= '0;
      scratch    <= '0;
      shift_cnt  <= '0;
      bcd        <= '0;
      bcd_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!bcd_valid || value != last_value) begin
            shreg     <= value;
            captured  <= value;
            scratch   <= '0;
            shift_cnt <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= {scratch_adj[14:0], shreg, 1'b0};
          shift_cnt        <= shift_cnt + 4'd1;
          if (shift_cnt == 4'(WIDTH - 1))
            state <= DONE;
        end
        DONE: begin
          bcd        <= scratch;
          bcd_valid  <= 1'b1;
          last_value <= captured;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ssd_display_driver.sv
// Four-digit common-anode seven-segment driver for the CPU's SSD debug bus.
// The binary value is converted to BCD by bin2bcd_seq. A free-running scan
// counter then time-multiplexes the digits onto the display.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous, active-low reset
//   value     - unsigned binary value to show, WIDTH bits
//   bcd       - last converted BCD {thousands,hundreds,tens,units}
//   bcd_valid - high once the first conversion has completed
//   busy      - conversion in progress
//   anode     - active-low digit enables, anode[0] drives the units digit
//   cathode   - active-low segments {g,f,e,d,c,b,a}
// Build option: define LEADING_ZERO_BLANK_EN to blank every digit above the
// most-significant nonzero one. The units digit is always shown. When the
// macro is undefined, all four digits are shown, including leading zeros.
module ssd_display_driver
  import ssd_pkg::*;
#(
  parameter int WIDTH        = 13,
  parameter int REFRESH_BITS = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  output logic [15:0]      bcd,
  output logic             bcd_valid,
  output logic             busy,
  output logic [3:0]       anode,
  output logic [6:0]       cathode
);

  logic [REFRESH_BITS-1:0] scan_cnt;
  logic [1:0]              digit_sel;
  logic [3:0]              nibble;
  logic                    lead_zero;
  logic [6:0]              seg_next;

  bin2bcd_seq #(.WIDTH(WIDTH)) u_conv (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .busy      (busy)
  );

  assign digit_sel = scan_cnt[REFRESH_BITS-1 -: 2];

  // Select the nibble for the digit being scanned. Also work out whether that
  // digit lies above the most-significant nonzero digit.
  always_comb begin
    nibble    = bcd[3:0];
    lead_zero = 1'b0;
    case (digit_sel)
      2'd0: begin
        nibble    = bcd[3:0];
        lead_zero = 1'b0;
      end
      2'd1: begin
        nibble    = bcd[7:4];
        lead_zero = (bcd[15:4] == 12'd0);
      end
      2'd2: begin
        nibble    = bcd[11:8];
        lead_zero = (bcd[15:8] == 8'd0);
      end
      default: begin
        nibble    = bcd[15:12];
        lead_zero = (bcd[15:12] == 4'd0);
      end
    endcase
  end

  // Decode the digit, or blank it when there is no result yet or the nibble
  // is not a decimal digit. The optional build also blanks leading zeros.
  always_comb begin
    seg_next = seg_encode(nibble);
    if (!bcd_valid)
      seg_next = SEG_BLANK;
`ifdef LEADING_ZERO_BLANK_EN
    if (lead_zero)
      seg_next = SEG_BLANK;
`endif
  end

  // Scan counter plus registered pin drivers. The pins follow the digit
  // select one cycle later, so exactly one anode is low after the first edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      anode    <= 4'b1111;
      cathode  <= SEG_BLANK;
    end else begin
      scan_cnt <= scan_cnt + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      anode    <= ~(4'b0001 << digit_sel);
      cathode  <= seg_next;
    end
  end

`ifndef LEADING_ZERO_BLANK_EN
  logic unused_lead_zero;
  assign unused_lead_zero = lead_zero;
`endif

endmodule

// File: tb/tb_ssd_display_driver.sv
// Self-checking bench for ssd_display_driver, built with a short scan counter.
// The reference model works from decimal arithmetic on the input value. It
// predicts the BCD result and the segment pattern each anode phase should show.
module tb_ssd_display_driver;

  localparam int WIDTH        = 13;
  localparam int REFRESH_BITS = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] value;
  logic [15:0]      bcd;
  logic             bcd_valid;
  logic             busy;
  logic [3:0]       anode;
  logic [6:0]       cathode;

  int tests_run;
  int tests_failed;

  typedef struct {
    int unsigned v;
    logic [15:0] exp_bcd;
  } vec_t;

  vec_t vecs[12];

  ssd_display_driver #(.WIDTH(WIDTH), .REFRESH_BITS(REFRESH_BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .busy      (busy),
    .anode     (anode),
    .cathode   (cathode)
  );

  // Free-running system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected BCD from plain decimal division.
  function automatic logic [15:0] model_bcd(input int unsigned v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] model_seg(input int unsigned d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected cathode for digit position i (0 = units) of value v.
  function automatic logic [6:0] model_cathode(input int unsigned v, input int i);
    int unsigned pw;
    pw = 1;
    for (int j = 0; j < i; j++) pw = pw * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && v < pw) return 7'h7F;
`endif
    return model_seg((v / pw) % 10);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int unsigned v);
    @(negedge clk);
    value = WIDTH'(v);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_bcd"}, bcd, 16'h0000);
    checkOutput({tag, "_valid"}, bcd_valid, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_anode"}, anode, 4'hF);
    checkOutput({tag, "_cathode"}, cathode, 7'h7F);
  endtask

  // Wait a bounded time for the result to settle, then compare it.
  task automatic waitConverged(input string name, input logic [15:0] exp_bcd);
    for (int k = 0; k < 60; k++) begin
      if (bcd_valid && !busy && bcd == exp_bcd) break;
      tick();
    end
    checkOutput(name, bcd, exp_bcd);
    checkOutput({name, "_valid"}, bcd_valid, 1'b1);
  endtask

  // Observe more than one full scan period. Each cycle must have one low
  // anode with the model's cathode, and every digit must appear at least once.
  task automatic checkScan(input int unsigned v);
    logic [3:0] seen;
    int idx;
    seen = 4'h0;
    for (int k = 0; k < 20; k++) begin
      tick();
      checkOutput("scan_one_low", $countones(~anode), 1);
      idx = -1;
      for (int i = 0; i < 4; i++) if (!anode[i]) idx = i;
      if (idx >= 0) begin
        seen[idx] = 1'b1;
        checkOutput($sformatf("scan_cathode_v%0d_d%0d", v, idx), cathode, model_cathode(v, idx));
      end
    end
    checkOutput("scan_cover", seen, 4'hF);
  endtask

  initial begin
    logic [15:0] prev_bcd;
    logic        saw_first;
    int          bad_vals;
    int          k;
    int unsigned v1;
    int unsigned v2;

    tests_run    = 0;
    tests_failed = 0;

    vecs[0]  = '{0,    16'h0000};
    vecs[1]  = '{8191, 16'h8191};
    vecs[2]  = '{1234, 16'h1234};
    vecs[3]  = '{4321, 16'h4321};
    vecs[4]  = '{42,   16'h0042};
    vecs[5]  = '{9,    16'h0009};
    vecs[6]  = '{10,   16'h0010};
    vecs[7]  = '{99,   16'h0099};
    vecs[8]  = '{100,  16'h0100};
    vecs[9]  = '{999,  16'h0999};
    vecs[10] = '{1000, 16'h1000};
    vecs[11] = '{5907, 16'h5907};

    // Reset with value 0, then release and time the first conversion.
    rst   = 1'b0;
    value = '0;
    repeat (2) tick();
    checkReset("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    while (!bcd_valid && k < 40) begin
      tick();
      k++;
    end
    checkOutput("init_latency", k, WIDTH + 2);
    checkOutput("init_bcd", bcd, 16'h0000);
    checkScan(0);

    // Table of directed values.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].v);
      waitConverged($sformatf("vec%0d", i), vecs[i].exp_bcd);
      checkScan(vecs[i].v);
    end

    // Exact latency and busy window for a single change.
    applyStimulus(8191);
    k = 0;
    while (bcd != 16'h8191 && k < 40) begin
      tick();
      k++;
      if (k == 1) checkOutput("lat_busy_rise", busy, 1'b1);
      if (k == WIDTH + 1) checkOutput("lat_busy_mid", busy, 1'b1);
    end
    checkOutput("lat_edges", k, WIDTH + 2);
    checkOutput("lat_busy_fall", busy, 1'b0);
    checkScan(8191);

    // Change during a conversion: only the two requested values may appear.
    prev_bcd  = bcd;
    saw_first = 1'b0;
    bad_vals  = 0;
    applyStimulus(1234);
    repeat (5) tick();
    @(negedge clk);
    value = WIDTH'(4321);
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bcd == 16'h1234) saw_first = 1'b1;
      if (bcd != prev_bcd && bcd != 16'h1234 && bcd != 16'h4321) bad_vals++;
    end
    checkOutput("chg_no_stray", bad_vals, 0);
    checkOutput("chg_saw_1234", saw_first, 1'b1);
    checkOutput("chg_final", bcd, 16'h4321);

    // Reset pulsed mid-conversion, then a full reconversion.
    applyStimulus(5555);
    repeat (7) tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkReset("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    waitConverged("rst_reconv", 16'h5555);
    checkScan(5555);

    // Randomised pairs against the decimal model, some changed while busy.
    for (int n = 0; n < 25; n++) begin
      v1 = $urandom_range(0, 8191);
      v2 = $urandom_range(0, 8191);
      applyStimulus(v1);
      repeat ($urandom_range(0, 20)) tick();
      applyStimulus(v2);
      waitConverged($sformatf("rand%0d_v%0d", n, v2), model_bcd(v2));
      if (n % 5 == 0) checkScan(v2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
